// File: rtl/step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and helpers for the step sequencer.
//                - state_t : sequencer run state
//                - step_w / track_w : address widths for the pattern store
//                - DEFAULT_GATE_CYCLES : 100 ms gate at the 50 MHz system clock
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int CLK_HZ              = 50_000_000;
    localparam int GATE_MS             = 100;
    localparam int DEFAULT_GATE_CYCLES = (CLK_HZ / 1000) * GATE_MS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Address width for n entries; a single-entry store still gets one bit
    // so that port declarations never collapse to zero width.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int step_w(input int num_steps);
        return clog2_min1(num_steps);
    endfunction

    function automatic int track_w(input int num_tracks);
        return clog2_min1(num_tracks);
    endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/step_sequencer_gate_timer.sv
`default_nettype none
// ============================================================================
//  Module      : gate_timer
//  Description : Shared gate timer for all tracks. A load latches the track
//                mask into the gate register and starts a GATE_CYCLES-long
//                window; a new load before expiry replaces the mask and
//                restarts the window, so retriggered tracks stay high.
//  Ports       : clk, reset    - clock, synchronous active-high reset
//                clear         - synchronous clear (sequencer stop)
//                load          - start a gate window with mask
//                mask          - per-track gate enables for this window
//                gate          - registered gate outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_timer
    import seq_pkg::*;
#(
    parameter int NUM_TRACKS  = 4,
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [NUM_TRACKS-1:0] mask,
    output logic [NUM_TRACKS-1:0] gate
);

    localparam int             CNT_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    // The load cycle itself is the first high cycle, so the counter starts
    // one short and the gate drops on the edge after it reaches zero.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(GATE_CYCLES - 1);

    logic [CNT_W-1:0]      cnt_q,  cnt_d;
    logic [NUM_TRACKS-1:0] gate_q, gate_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            gate_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            gate_q <= gate_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        gate_d = gate_q;
        if (clear) begin
            cnt_d  = '0;
            gate_d = '0;
        end else if (load) begin
            cnt_d  = RELOAD;
            gate_d = mask;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
        end else begin
            gate_d = '0;
        end
    end

    assign gate = gate_q;

endmodule : gate_timer
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : step_sequencer
//  Description : Pattern step sequencer. Each BPM tick seen while running
//                fires the next step of a NUM_STEPS x NUM_TRACKS on/off
//                pattern: a one-cycle trigger plus a fixed-length gate for
//                every active track, and a step index / beat indicator for
//                the display.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                tick               - one-cycle step pulse
//                play               - level, run (1) / pause (0)
//                stop               - one-cycle stop-and-rewind pulse
//                wr_en/wr_step/wr_track/wr_val - pattern cell write
//                step_idx           - most recently fired step
//                trig, gate         - per-track trigger and gate
//                beat_led           - last fired step was even
//                running            - sequencer is in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module step_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_STEPS   = 16,   // power of two, >= 2
    parameter int NUM_TRACKS  = 4,
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tick,
    input  logic                             play,
    input  logic                             stop,
    input  logic                             wr_en,
    input  logic [step_w(NUM_STEPS)-1:0]     wr_step,
    input  logic [track_w(NUM_TRACKS)-1:0]   wr_track,
    input  logic                             wr_val,
    output logic [step_w(NUM_STEPS)-1:0]     step_idx,
    output logic [NUM_TRACKS-1:0]            trig,
    output logic [NUM_TRACKS-1:0]            gate,
    output logic                             beat_led,
    output logic                             running
);

    localparam int STEP_W = step_w(NUM_STEPS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [STEP_W-1:0]     ptr_q, ptr_d;          // next step to fire
    logic [STEP_W-1:0]     step_idx_q, step_idx_d;
    logic                  beat_led_q, beat_led_d;
    logic [NUM_TRACKS-1:0] trig_q, trig_d;
    logic [NUM_TRACKS-1:0] pattern_q [NUM_STEPS];
    logic [NUM_TRACKS-1:0] pattern_d [NUM_STEPS];

    logic                  fire;
    logic [NUM_TRACKS-1:0] fire_mask;

    // ------------------------------------------------------------------
    // Register process
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            step_idx_q <= '0;
            beat_led_q <= 1'b0;
            trig_q     <= '0;
            for (int s = 0; s < NUM_STEPS; s++) begin
                pattern_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            step_idx_q <= step_idx_d;
            beat_led_q <= beat_led_d;
            trig_q     <= trig_d;
            for (int s = 0; s < NUM_STEPS; s++) begin
                pattern_q[s] <= pattern_d[s];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state process
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (play)  state_d = ST_RUN;
                ST_RUN:   if (!play) state_d = ST_PAUSE;
                ST_PAUSE: if (play)  state_d = ST_RUN;
                default:             state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Step firing and pattern store
    // ------------------------------------------------------------------
    // Only a tick seen while already in RUN fires; a tick arriving in the
    // cycle play rises is dropped because state_q is still IDLE/PAUSE.
    // The fire reads pattern_q, so a write to the same cell this cycle is
    // only seen on the next pass.
    assign fire      = (state_q == ST_RUN) && tick && !stop;
    assign fire_mask = pattern_q[ptr_q];

    always_comb begin
        ptr_d      = ptr_q;
        step_idx_d = step_idx_q;
        beat_led_d = beat_led_q;
        trig_d     = '0;
        for (int s = 0; s < NUM_STEPS; s++) begin
            pattern_d[s] = pattern_q[s];
        end

        if (stop) begin
            ptr_d      = '0;
            step_idx_d = '0;
            beat_led_d = 1'b0;
        end else if (fire) begin
            trig_d     = fire_mask;
            step_idx_d = ptr_q;
            beat_led_d = ~ptr_q[0];
            // NUM_STEPS is a power of two, so the increment wraps on its own.
            ptr_d      = ptr_q + STEP_W'(1);
        end

        if (wr_en && (int'(wr_track) < NUM_TRACKS)) begin
            pattern_d[wr_step][wr_track] = wr_val;
        end
    end

    // ------------------------------------------------------------------
    // Gate generation
    // ------------------------------------------------------------------
    gate_timer #(
        .NUM_TRACKS  (NUM_TRACKS),
        .GATE_CYCLES (GATE_CYCLES)
    ) u_gate_timer (
        .clk   (clk),
        .reset (reset),
        .clear (stop),
        .load  (fire),
        .mask  (fire_mask),
        .gate  (gate)
    );

    // ------------------------------------------------------------------
    // Output process
    // ------------------------------------------------------------------
    always_comb begin
        running  = (state_q == ST_RUN);
        step_idx = step_idx_q;
        beat_led = beat_led_q;
        trig     = trig_q;
    end

endmodule : step_sequencer
`default_nettype wire
